// File: rtl/complex_divider_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// complex_divider_pkg : FSM states, width helpers and default sizing
// Rev 1.0
// ----------------------------------------------------------------------------
package complex_divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PROD = 3'd1,
    S_DIV  = 3'd2,
    S_FIN  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic int div_w(input int b_w);
    return 2 * b_w;
  endfunction

  function automatic int iter_n(input int a_w, input int b_w, input int frac_w);
    return prod_w(a_w, b_w) + frac_w;
  endfunction

  localparam int c_DEF_A_W    = 16;
  localparam int c_DEF_B_W    = 18;
  localparam int c_DEF_FRAC_W = 15;
  localparam int c_DEF_Q_W    = 32;
  localparam int c_PROD_W     = prod_w(c_DEF_A_W, c_DEF_B_W);
  localparam int c_DIV_W      = div_w(c_DEF_B_W);
  localparam int c_ITER_N     = c_PROD_W + c_DEF_FRAC_W;

endpackage
`default_nettype wire

// File: rtl/complex_divider_serial_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_divider : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module serial_divider
  import complex_divider_pkg::*;
#(
  parameter int DIVIDEND_W = c_ITER_N,
  parameter int DIVISOR_W  = c_DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_done,
  output logic [DIVIDEND_W-1:0] o_quotient
);

  localparam int c_CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_ge;

  // Remainder stays below the divisor, so the trial difference fits one extra bit.
  always_comb begin
    w_shift = {r_rem, r_quot[DIVIDEND_W-1]};
    w_diff  = w_shift - {1'b0, r_divisor};
    w_ge    = ~w_diff[DIVISOR_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else if (i_start) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
      r_cnt     <= c_CNT_W'(DIVIDEND_W);
    end else if (r_cnt != '0) begin
      r_rem  <= w_ge ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
      r_quot <= {r_quot[DIVIDEND_W-2:0], w_ge};
      r_cnt  <= r_cnt - c_CNT_W'(1);
    end
  end

  // High during the cycle whose closing edge produces the final quotient bit.
  assign o_done     = (r_cnt == c_CNT_W'(1));
  assign o_quotient = r_quot;

endmodule
`default_nettype wire

// File: rtl/complex_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// complex_divider : iterative q = a*conj(b)/|b|^2, signed fixed-point result
// Rev 1.0
// ----------------------------------------------------------------------------
module complex_divider
  import complex_divider_pkg::*;
#(
  parameter int A_W    = c_DEF_A_W,
  parameter int B_W    = c_DEF_B_W,
  parameter int FRAC_W = c_DEF_FRAC_W,
  parameter int Q_W    = c_DEF_Q_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] real_part_a,
  input  logic [A_W-1:0] imag_part_a,
  input  logic [B_W-1:0] real_part_b,
  input  logic [B_W-1:0] imag_part_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] real_quot,
  output logic [Q_W-1:0] imag_quot,
  output logic           div_by_zero,
  output logic           saturated
);

  localparam int c_PW    = prod_w(A_W, B_W);
  localparam int c_DW    = div_w(B_W);
  localparam int c_NW    = iter_n(A_W, B_W, FRAC_W);
  localparam int c_EXT_W = (c_NW > Q_W) ? c_NW : Q_W;
  localparam logic [Q_W-1:0] c_Q_MAX = {1'b0, {(Q_W-1){1'b1}}};

  state_e                r_state;
  logic                  r_in_ready, r_out_valid, r_dz, r_sat;
  logic [Q_W-1:0]        r_real_quot, r_imag_quot;
  logic [A_W-1:0]        r_ar, r_ai;
  logic [B_W-1:0]        r_br, r_bi;
  logic                  r_nr_neg, r_ni_neg, r_d_zero;
  logic signed [c_PW-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x, w_nr, w_ni;
  logic signed [c_DW-1:0] w_br_d, w_bi_d;
  logic [c_DW-1:0]       w_d;
  logic [c_PW-1:0]       w_nr_mag, w_ni_mag;
  logic [c_NW-1:0]       w_q_r, w_q_i;
  logic                  w_start, w_done_r, w_done_i;
  logic [Q_W:0]          w_fr, w_fi;

  // Returns {clamped, signed value}; the magnitude is clamped before the sign goes back on.
  function automatic logic [Q_W:0] clamp_sign(input logic [c_NW-1:0] mag, input logic neg);
    logic [c_EXT_W-1:0] ext;
    logic [Q_W-1:0]     m;
    logic               ovf;
    ext = c_EXT_W'(mag);
    ovf = ext > c_EXT_W'(c_Q_MAX);
    m   = ovf ? c_Q_MAX : ext[Q_W-1:0];
    return {ovf, neg ? -m : m};
  endfunction

  always_comb begin
    w_ar_x   = {{(c_PW-A_W){r_ar[A_W-1]}}, r_ar};
    w_ai_x   = {{(c_PW-A_W){r_ai[A_W-1]}}, r_ai};
    w_br_x   = {{(c_PW-B_W){r_br[B_W-1]}}, r_br};
    w_bi_x   = {{(c_PW-B_W){r_bi[B_W-1]}}, r_bi};
    w_nr     = w_ar_x * w_br_x + w_ai_x * w_bi_x;
    w_ni     = w_ai_x * w_br_x - w_ar_x * w_bi_x;
    w_br_d   = {{(c_DW-B_W){r_br[B_W-1]}}, r_br};
    w_bi_d   = {{(c_DW-B_W){r_bi[B_W-1]}}, r_bi};
    w_d      = w_br_d * w_br_d + w_bi_d * w_bi_d;
    w_nr_mag = w_nr[c_PW-1] ? -w_nr : w_nr;
    w_ni_mag = w_ni[c_PW-1] ? -w_ni : w_ni;
    w_start  = (r_state == S_PROD) && (w_d != '0);
    w_fr     = clamp_sign(w_q_r, r_nr_neg);
    w_fi     = clamp_sign(w_q_i, r_ni_neg);
  end

  serial_divider #(.DIVIDEND_W(c_NW), .DIVISOR_W(c_DW)) u_div_real (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend ({w_nr_mag, {FRAC_W{1'b0}}}),
    .i_divisor  (w_d),
    .o_done     (w_done_r),
    .o_quotient (w_q_r)
  );

  serial_divider #(.DIVIDEND_W(c_NW), .DIVISOR_W(c_DW)) u_div_imag (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend ({w_ni_mag, {FRAC_W{1'b0}}}),
    .i_divisor  (w_d),
    .o_done     (w_done_i),
    .o_quotient (w_q_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_real_quot <= '0;
      r_imag_quot <= '0;
      r_dz        <= 1'b0;
      r_sat       <= 1'b0;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_nr_neg    <= 1'b0;
      r_ni_neg    <= 1'b0;
      r_d_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_ar       <= real_part_a;
          r_ai       <= imag_part_a;
          r_br       <= real_part_b;
          r_bi       <= imag_part_b;
          r_in_ready <= 1'b0;
          r_state    <= S_PROD;
        end
        S_PROD: begin
          r_nr_neg <= w_nr[c_PW-1];
          r_ni_neg <= w_ni[c_PW-1];
          r_d_zero <= (w_d == '0);
          r_state  <= (w_d == '0) ? S_FIN : S_DIV;
        end
        S_DIV: if (w_done_r && w_done_i) r_state <= S_FIN;
        S_FIN: begin
          r_real_quot <= r_d_zero ? '0 : w_fr[Q_W-1:0];
          r_imag_quot <= r_d_zero ? '0 : w_fi[Q_W-1:0];
          r_dz        <= r_d_zero;
          r_sat       <= ~r_d_zero & (w_fr[Q_W] | w_fi[Q_W]);
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign real_quot   = r_real_quot;
  assign imag_quot   = r_imag_quot;
  assign div_by_zero = r_dz;
  assign saturated   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_complex_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_complex_divider : two instances (Q_W 32 and 24) against an arithmetic model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_complex_divider;

  localparam int A_W = 16, B_W = 18, FRAC_W = 15, Q_W = 32, Q_S = 24;
  localparam int LAT = A_W + B_W + 1 + FRAC_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic signed [A_W-1:0] ar = '0, ai = '0;
  logic signed [B_W-1:0] br = '0, bi = '0;
  logic ir32, ov32, dz32, sat32, ir24, ov24, dz24, sat24;
  logic [Q_W-1:0] rq32, iq32;
  logic [Q_S-1:0] rq24, iq24;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  complex_divider #(.A_W(A_W), .B_W(B_W), .FRAC_W(FRAC_W), .Q_W(Q_W)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .out_valid(ov32), .out_ready(out_ready), .real_quot(rq32), .imag_quot(iq32),
    .div_by_zero(dz32), .saturated(sat32));

  complex_divider #(.A_W(A_W), .B_W(B_W), .FRAC_W(FRAC_W), .Q_W(Q_S)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir24),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .out_valid(ov24), .out_ready(out_ready), .real_quot(rq24), .imag_quot(iq24),
    .div_by_zero(dz24), .saturated(sat24));

  // q = a*conj(b)/|b|^2 with truncation toward zero and symmetric clamping.
  function automatic void model(input longint a_r, a_i, b_r, b_i, input int qw,
                                output longint rq, iq, output bit dz, sat);
    longint nr, ni, d, mr, mi, mx;
    nr = a_r * b_r + a_i * b_i;
    ni = a_i * b_r - a_r * b_i;
    d  = b_r * b_r + b_i * b_i;
    mx = (longint'(1) << (qw - 1)) - 1;
    dz = (d == 0); sat = 0; rq = 0; iq = 0;
    if (d != 0) begin
      mr = ((nr < 0) ? -nr : nr) * (longint'(1) << FRAC_W) / d;
      mi = ((ni < 0) ? -ni : ni) * (longint'(1) << FRAC_W) / d;
      if (mr > mx) begin mr = mx; sat = 1; end
      if (mi > mx) begin mi = mx; sat = 1; end
      rq = (nr < 0) ? -mr : mr;
      iq = (ni < 0) ? -mi : mi;
    end
  endfunction

  // Issues one operand set, keeps in_valid high with junk while busy, returns latency (-1 on timeout).
  task automatic do_op(input longint a_r, a_i, b_r, b_i, output int lat);
    ar = A_W'(a_r); ai = A_W'(a_i); br = B_W'(b_r); bi = B_W'(b_i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!(ov32 && ov24) && lat < 200) begin
      ar = A_W'($urandom); ai = A_W'($urandom); br = B_W'($urandom); bi = B_W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (lat >= 200) lat = -1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({ir32, ir24} !== 2'b11) $display("FAIL reset_in_ready: got %b expected 11", {ir32, ir24}); else n_pass++;
    n_chk++; if ({ov32, ov24} !== 2'b00) $display("FAIL reset_out_valid: got %b expected 00", {ov32, ov24}); else n_pass++;
    n_chk++; if (rq32 !== '0 || iq32 !== '0 || rq24 !== '0 || iq24 !== '0)
      $display("FAIL reset_quot: got %0h %0h %0h %0h expected 0", rq32, iq32, rq24, iq24); else n_pass++;
    n_chk++; if ({dz32, sat32, dz24, sat24} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {dz32, sat32, dz24, sat24}); else n_pass++;
  endtask

  task automatic test_directed();
    longint t_a[4][4] = '{'{3, 4, 1, 2}, '{8, 0, 2, 0}, '{5, -7, 0, 0}, '{-32768, -32768, 1, 0}};
    longint e32[4][2] = '{'{72089, -13107}, '{131072, 0}, '{0, 0}, '{-1073741824, -1073741824}};
    longint e24[4][2] = '{'{72089, -13107}, '{131072, 0}, '{0, 0}, '{-8388607, -8388607}};
    logic [2:0] ef[4] = '{3'b000, 3'b000, 3'b100, 3'b001};  // {dz, sat32, sat24}
    int el[4] = '{LAT, LAT, 3, LAT};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(t_a[i][0], t_a[i][1], t_a[i][2], t_a[i][3], lat);
      n_chk++; if (lat !== el[i]) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el[i]); else n_pass++;
      n_chk++; if (longint'($signed(rq32)) !== e32[i][0] || longint'($signed(iq32)) !== e32[i][1])
        $display("FAIL dir_quot32[%0d]: got %0d,%0d expected %0d,%0d", i, $signed(rq32), $signed(iq32), e32[i][0], e32[i][1]); else n_pass++;
      n_chk++; if (longint'($signed(rq24)) !== e24[i][0] || longint'($signed(iq24)) !== e24[i][1])
        $display("FAIL dir_quot24[%0d]: got %0d,%0d expected %0d,%0d", i, $signed(rq24), $signed(iq24), e24[i][0], e24[i][1]); else n_pass++;
      n_chk++; if ({dz32, dz24, sat32, sat24} !== {ef[i][2], ef[i][2], ef[i][1], ef[i][0]})
        $display("FAIL dir_flags[%0d]: got %b expected %b", i, {dz32, dz24, sat32, sat24}, {ef[i][2], ef[i][2], ef[i][1], ef[i][0]}); else n_pass++;
      accept();
      n_chk++; if ({ir32, ir24} !== 2'b11) $display("FAIL dir_in_ready_after[%0d]: got %b expected 11", i, {ir32, ir24}); else n_pass++;
    end
  endtask

  task automatic test_random();
    longint a_r, a_i, b_r, b_i, r32, i32, r24, i24;
    bit dz, s32, s24;
    int lat, mode;
    for (int i = 0; i < 40; i++) begin
      a_r = longint'($signed(A_W'($urandom)));
      a_i = longint'($signed(A_W'($urandom)));
      mode = int'($urandom_range(0, 3));
      if (mode == 1) begin
        b_r = longint'($urandom_range(0, 6)) - 3;
        b_i = longint'($urandom_range(0, 6)) - 3;
      end else if (mode == 2) begin
        b_r = 0; b_i = 0;
      end else begin
        b_r = longint'($signed(B_W'($urandom)));
        b_i = longint'($signed(B_W'($urandom)));
      end
      model(a_r, a_i, b_r, b_i, Q_W, r32, i32, dz, s32);
      model(a_r, a_i, b_r, b_i, Q_S, r24, i24, dz, s24);
      do_op(a_r, a_i, b_r, b_i, lat);
      n_chk++; if (lat !== (dz ? 3 : LAT)) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, dz ? 3 : LAT); else n_pass++;
      n_chk++; if (longint'($signed(rq32)) !== r32 || longint'($signed(iq32)) !== i32)
        $display("FAIL rnd_quot32[%0d]: got %0d,%0d expected %0d,%0d", i, $signed(rq32), $signed(iq32), r32, i32); else n_pass++;
      n_chk++; if (longint'($signed(rq24)) !== r24 || longint'($signed(iq24)) !== i24)
        $display("FAIL rnd_quot24[%0d]: got %0d,%0d expected %0d,%0d", i, $signed(rq24), $signed(iq24), r24, i24); else n_pass++;
      n_chk++; if ({dz32, sat32, dz24, sat24} !== {dz, s32, dz, s24})
        $display("FAIL rnd_flags[%0d]: got %b expected %b", i, {dz32, sat32, dz24, sat24}, {dz, s32, dz, s24}); else n_pass++;
      accept();
    end
  endtask

  task automatic test_back_pressure();
    longint r32, i32, r24, i24;
    bit dz, s32, s24, bad;
    int lat;
    model(-1234, 777, -3, 2, Q_W, r32, i32, dz, s32);
    model(-1234, 777, -3, 2, Q_S, r24, i24, dz, s24);
    do_op(-1234, 777, -3, 2, lat);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ar = A_W'($urandom); br = B_W'($urandom);
      @(posedge clk); #1;
      if (!(ov32 && ov24) || ir32 || ir24 || longint'($signed(rq32)) !== r32 || longint'($signed(iq32)) !== i32
          || longint'($signed(rq24)) !== r24 || longint'($signed(iq24)) !== i24 || {dz32, sat32, sat24} !== {dz, s32, s24})
        bad = 1'b1;
    end
    in_valid = 1'b0;
    n_chk++; if (bad !== 1'b0) $display("FAIL hold_stable: got unstable=%b expected 0", bad); else n_pass++;
    accept();
    n_chk++; if ({ir32, ir24, ov32, ov24} !== 4'b1100) $display("FAIL hold_release: got %b expected 1100", {ir32, ir24, ov32, ov24}); else n_pass++;
    model(20000, -15000, 300, -40, Q_W, r32, i32, dz, s32);
    do_op(20000, -15000, 300, -40, lat);
    n_chk++; if (lat !== LAT || longint'($signed(rq32)) !== r32 || longint'($signed(iq32)) !== i32)
      $display("FAIL hold_next_op: got lat %0d %0d,%0d expected lat %0d %0d,%0d", lat, $signed(rq32), $signed(iq32), LAT, r32, i32); else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    longint r32, i32, r24, i24;
    bit dz, s32, s24, bad;
    int lat;
    ar = 100; ai = -200; br = 7; bi = 9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    n_chk++; if ({ir32, ir24, ov32, ov24} !== 4'b1100) $display("FAIL midrst_async: got %b expected 1100", {ir32, ir24, ov32, ov24}); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (ov32 || ov24 || !ir32 || !ir24) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) $display("FAIL midrst_quiet: got spurious=%b expected 0", bad); else n_pass++;
    model(-9999, 4321, -77, 123, Q_W, r32, i32, dz, s32);
    model(-9999, 4321, -77, 123, Q_S, r24, i24, dz, s24);
    do_op(-9999, 4321, -77, 123, lat);
    n_chk++; if (lat !== LAT || longint'($signed(rq32)) !== r32 || longint'($signed(iq32)) !== i32 || longint'($signed(rq24)) !== r24)
      $display("FAIL midrst_next_op: got lat %0d %0d,%0d expected lat %0d %0d,%0d", lat, $signed(rq32), $signed(iq32), LAT, r32, i32); else n_pass++;
    accept();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
